// File: rtl/dds_baud_gen.sv
// Multi-channel fractional (DDS) baud generator: a modulo-TOP phase accumulator per channel
// emits oversample ticks, and a divide-by-OVS counter derives the bit-rate tick from them.
module dds_baud_gen #(
  parameter int unsigned CH    = 2,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned INC_W = 16,
  parameter int unsigned TOP   = 31250,
  parameter int unsigned OVS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     en,
  input  logic [CH*INC_W-1:0] inc,
  input  logic [CH-1:0]     resync,
  output logic [CH-1:0]     tick_os,
  output logic [CH-1:0]     tick_bit,
  output logic [CH-1:0]     cfg_err
);

  localparam int unsigned OS_W  = $clog2(OVS);
  localparam int unsigned SW    = ACC_W + 1;
  localparam int unsigned CMP_W = (INC_W > SW) ? INC_W : SW;

  localparam logic [CMP_W-1:0] TOP_C  = CMP_W'(TOP);
  localparam logic [SW-1:0]    TOP_S  = SW'(TOP);
  localparam logic [OS_W-1:0]  OS_MAX = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]  OS_MID = OS_W'(OVS / 2);
  localparam logic [OS_W-1:0]  OS_ONE = OS_W'(1);

  logic [ACC_W-1:0] acc_q    [CH];
  logic [ACC_W-1:0] acc_d    [CH];
  logic [OS_W-1:0]  os_cnt_q [CH];
  logic [OS_W-1:0]  os_cnt_d [CH];
  logic [CMP_W-1:0] inc_ext  [CH];
  logic [SW-1:0]    eff      [CH];
  logic [SW-1:0]    sum      [CH];

  logic [CH-1:0] clamp;
  logic [CH-1:0] tick_os_q, tick_os_d;
  logic [CH-1:0] tick_bit_q, tick_bit_d;
  logic [CH-1:0] cfg_err_q, cfg_err_d;

  always_comb begin
    for (int unsigned k = 0; k < CH; k++) begin
      inc_ext[k]  = CMP_W'(inc[k*INC_W +: INC_W]);
      clamp[k]    = (inc_ext[k] > TOP_C);
      // Unclamped increments are <= TOP, so the low SW bits hold them exactly.
      eff[k]      = clamp[k] ? TOP_S : inc_ext[k][SW-1:0];
      sum[k]      = {1'b0, acc_q[k]} + eff[k];

      acc_d[k]      = acc_q[k];
      os_cnt_d[k]   = os_cnt_q[k];
      tick_os_d[k]  = 1'b0;
      tick_bit_d[k] = 1'b0;
      cfg_err_d[k]  = cfg_err_q[k] | (en[k] & clamp[k]);

      if (resync[k]) begin
        acc_d[k]    = '0;
        os_cnt_d[k] = OS_MID;
      end else if (en[k]) begin
        if ({1'b0, acc_q[k]} >= TOP_S) begin
          acc_d[k]      = ACC_W'(sum[k] - TOP_S);
          tick_os_d[k]  = 1'b1;
          tick_bit_d[k] = (os_cnt_q[k] == OS_MAX);
          os_cnt_d[k]   = os_cnt_q[k] + OS_ONE;
        end else begin
          acc_d[k] = ACC_W'(sum[k]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CH; k++) begin
        acc_q[k]    <= '0;
        os_cnt_q[k] <= '0;
      end
      tick_os_q  <= '0;
      tick_bit_q <= '0;
      cfg_err_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < CH; k++) begin
        acc_q[k]    <= acc_d[k];
        os_cnt_q[k] <= os_cnt_d[k];
      end
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick_os  = tick_os_q;
  assign tick_bit = tick_bit_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_dds_baud_gen.sv
// Bench for dds_baud_gen: a full-size instance and a small TOP=10/OVS=4 instance, both
// tracked cycle by cycle against an integer reference model of the baud-generator rules.
module tb_dds_baud_gen;

  typedef struct {
    int acc;
    int os;
    bit tos;
    bit tbit;
    bit err;
  } ch_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en_b, rs_b, tos_b, tbit_b, err_b;
  logic [31:0] inc_b;
  logic [1:0]  en_s, rs_s, tos_s, tbit_s, err_s;
  logic [31:0] inc_s;

  ch_t mb[2], ms[2];
  logic [11:0] exp_all;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dds_baud_gen u_big (
    .clk(clk), .rst_n(rst_n), .en(en_b), .inc(inc_b), .resync(rs_b),
    .tick_os(tos_b), .tick_bit(tbit_b), .cfg_err(err_b)
  );

  dds_baud_gen #(.CH(2), .ACC_W(16), .INC_W(16), .TOP(10), .OVS(4)) u_small (
    .clk(clk), .rst_n(rst_n), .en(en_s), .inc(inc_s), .resync(rs_s),
    .tick_os(tos_s), .tick_bit(tbit_s), .cfg_err(err_s)
  );

  always #5 clk = ~clk;

  function automatic ch_t ref_next(ch_t s, int top, int ovs, bit rstn, bit en, int inc, bit rs);
    ch_t n;
    int  eff;
    if (!rstn) begin
      n = '{acc: 0, os: 0, tos: 0, tbit: 0, err: 0};
      return n;
    end
    n      = s;
    n.tos  = 0;
    n.tbit = 0;
    eff    = (inc > top) ? top : inc;
    if (en && inc > top) n.err = 1;
    if (rs) begin
      n.acc = 0;
      n.os  = ovs / 2;
    end else if (en) begin
      if (s.acc >= top) begin
        n.acc  = s.acc + eff - top;
        n.tos  = 1;
        n.tbit = (s.os == ovs - 1);
        n.os   = (s.os + 1) % ovs;
      end else begin
        n.acc = s.acc + eff;
      end
    end
    return n;
  endfunction

  // Advance model and DUTs by one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    ch_t nb[2], ns[2];
    for (int k = 0; k < 2; k++) begin
      nb[k] = ref_next(mb[k], 31250, 16, rst_n, en_b[k], int'(inc_b[k*16 +: 16]), rs_b[k]);
      ns[k] = ref_next(ms[k], 10, 4, rst_n, en_s[k], int'(inc_s[k*16 +: 16]), rs_s[k]);
    end
    @(posedge clk);
    #1;
    mb = nb;
    ms = ns;
    exp_all = {mb[1].tos, mb[0].tos, mb[1].tbit, mb[0].tbit, mb[1].err, mb[0].err,
               ms[1].tos, ms[0].tos, ms[1].tbit, ms[0].tbit, ms[1].err, ms[0].err};
    cyc++;
  endtask

  function automatic logic [11:0] obs_all();
    return {tos_b, tbit_b, err_b, tos_s, tbit_s, err_s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en_b = '1; rs_b = '0; inc_b = {16'd40000, 16'd31250};
    en_s = '1; rs_s = '0; inc_s = {16'd25, 16'd10};
    step();
    step();
    checks++;
    if (obs_all() !== 12'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero", obs_all());
    end
    checks++;
    if (u_small.acc_q[0] !== 16'd0 || u_big.acc_q[1] !== 16'd0) begin
      errors++;
      $display("FAIL reset_acc: small0=%0d big1=%0d, want 0", u_small.acc_q[0], u_big.acc_q[1]);
    end
  endtask

  task automatic test_small_pattern();
    int n_os = 0, n_bit = 0;
    rst_n = 1'b1;
    en_b = '0; inc_b = '0;
    en_s = 2'b11;
    inc_s = {16'($urandom_range(10, 0)), 16'd5};
    for (int i = 0; i < 40; i++) begin
      step();
      n_os  += int'(tos_s[0]);
      n_bit += int'(tbit_s[0]);
      checks++;
      if (obs_all() !== exp_all || int'(u_small.acc_q[0]) !== ms[0].acc) begin
        errors++;
        $display("FAIL small_pattern cyc%0d: out=%b acc=%0d want out=%b acc=%0d",
                 i, obs_all(), u_small.acc_q[0], exp_all, ms[0].acc);
      end
    end
    checks++;
    if (n_os !== 19 || n_bit !== 4) begin
      errors++;
      $display("FAIL small_counts: tick_os=%0d tick_bit=%0d, want 19 and 4", n_os, n_bit);
    end
  endtask

  task automatic test_rate();
    int n_os = 0;
    bit prev = 0, back2back = 0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    en_b  = {1'($urandom_range(1, 0)), 1'b1};
    inc_b = {16'($urandom_range(31250, 1)), 16'd1152};
    en_s  = '0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (tos_b[0] && prev) back2back = 1;
      prev = tos_b[0];
      n_os += int'(tos_b[0]);
      checks++;
      if (obs_all() !== exp_all) begin
        errors++;
        $display("FAIL rate cyc%0d: got %b want %b", i, obs_all(), exp_all);
      end
    end
    checks++;
    if (n_os < 183 || n_os > 185 || back2back) begin
      errors++;
      $display("FAIL rate_count: tick_os=%0d consecutive=%0d, want 184+-1 and 0", n_os, back2back);
    end
  endtask

  task automatic test_resync();
    int  n_os = 0;
    bit  found = 0;
    inc_b = {16'($urandom_range(31250, 5000)), 16'($urandom_range(31250, 20000))};
    en_b  = 2'b11;
    for (int i = 0; i < 50; i++) step();
    rs_b[0] = 1'b1;
    step();
    rs_b[0] = 1'b0;
    checks++;
    if (tos_b[0] !== 1'b0 || tbit_b[0] !== 1'b0 || u_big.acc_q[0] !== 16'd0 || obs_all() !== exp_all) begin
      errors++;
      $display("FAIL resync_cycle: tos=%b bit=%b acc=%0d out=%b, want 0 0 0 out=%b",
               tos_b[0], tbit_b[0], u_big.acc_q[0], obs_all(), exp_all);
    end
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      n_os += int'(tos_b[0]);
      if (tbit_b[0]) found = 1;
      checks++;
      if (obs_all() !== exp_all) begin
        errors++;
        $display("FAIL resync_run cyc%0d: got %b want %b", i, obs_all(), exp_all);
      end
    end
    checks++;
    if (!found || n_os !== 8) begin
      errors++;
      $display("FAIL resync_midbit: found=%0d tick_os_before_bit=%0d, want 1 and 8", found, n_os);
    end
  endtask

  task automatic test_enable_gap();
    int held;
    int n_ticks = 0;
    en_s  = 2'b11;
    inc_s = {16'd7, 16'($urandom_range(9, 3))};
    for (int i = 0; i < 13; i++) step();
    held = ms[0].acc;
    en_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_ticks += int'(tos_s[0]) + int'(tbit_s[0]);
      checks++;
      if (int'(u_small.acc_q[0]) !== held || obs_all() !== exp_all) begin
        errors++;
        $display("FAIL en_gap cyc%0d: acc=%0d out=%b, want acc=%0d out=%b",
                 i, u_small.acc_q[0], obs_all(), held, exp_all);
      end
    end
    checks++;
    if (n_ticks !== 0) begin
      errors++;
      $display("FAIL en_gap_ticks: got %0d ticks, want 0", n_ticks);
    end
    en_s[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs_all() !== exp_all || int'(u_small.acc_q[0]) !== ms[0].acc) begin
        errors++;
        $display("FAIL en_resume cyc%0d: out=%b acc=%0d want out=%b acc=%0d",
                 i, obs_all(), u_small.acc_q[0], exp_all, ms[0].acc);
      end
    end
  endtask

  task automatic test_cfg_err();
    inc_s[15:0] = 16'd25;
    step();
    checks++;
    if (err_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_set: got %b want 1", err_s[0]);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (tos_s[0] !== 1'b1 || err_s[0] !== 1'b1 || obs_all() !== exp_all) begin
        errors++;
        $display("FAIL cfg_err_clamp cyc%0d: tos=%b err=%b out=%b want 1 1 out=%b",
                 i, tos_s[0], err_s[0], obs_all(), exp_all);
      end
    end
    inc_s[15:0] = 16'd3;
    en_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (err_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_sticky: got %b want 1", err_s[0]);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (err_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear: got %b want 0", err_s[0]);
    end
  endtask

  task automatic test_reset_mid();
    en_b = 2'b11; inc_b = {16'd31250, 16'd31250};
    en_s = 2'b11; inc_s = {16'd10, 16'd10};
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (obs_all() !== 12'b0 || u_small.acc_q[1] !== 16'd0 || u_big.acc_q[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: out=%b, want all zero and acc 0", obs_all());
    end
    step();
    checks++;
    if (tos_s !== 2'b00 || tos_b !== 2'b00) begin
      errors++;
      $display("FAIL reset_first_edge: tos_s=%b tos_b=%b want 00 00", tos_s, tos_b);
    end
    step();
    checks++;
    if (tos_s !== 2'b11 || tos_b !== 2'b11 || obs_all() !== exp_all) begin
      errors++;
      $display("FAIL reset_first_tick: tos_s=%b tos_b=%b want 11 11", tos_s, tos_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(299, 0) != 0);
      for (int k = 0; k < 2; k++) begin
        en_b[k] = ($urandom_range(4, 0) != 0);
        rs_b[k] = ($urandom_range(40, 0) == 0);
        en_s[k] = ($urandom_range(4, 0) != 0);
        rs_s[k] = ($urandom_range(40, 0) == 0);
        inc_b[k*16 +: 16] = ($urandom_range(15, 0) == 0) ? 16'($urandom_range(65535, 31251))
                                                         : 16'($urandom_range(31250, 0));
        inc_s[k*16 +: 16] = 16'($urandom_range(13, 0));
      end
      step();
      checks++;
      if (obs_all() !== exp_all) begin
        errors++;
        $display("FAIL random cyc%0d: got %b want %b", i, obs_all(), exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_small_pattern();
    test_rate();
    test_resync();
    test_enable_gap();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_baud_gen.md
DDS_BAUD_GEN -- requirements
Module: dds_baud_gen

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent channels.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width.
REQ-003 SHALL have parameter INC_W, default 16: per-channel increment width.
REQ-004 SHALL have parameter TOP, default 31250: accumulator modulus, shared by all channels.
REQ-005 SHALL have parameter OVS, default 16: oversample ticks per bit tick; power of two, at least 2.
REQ-006 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-008 SHALL have port en  input  CH: per-channel run enable.
REQ-009 SHALL have port inc  input  CH*INC_W: packed per-channel increment (baudrate); channel k at bits [k*INC_W +: INC_W].
REQ-010 SHALL have port resync  input  CH: per-channel phase realign, e.g. on RX start-bit edge.
REQ-011 SHALL have port tick_os  output  CH: per-channel oversample enable pulse, one cycle wide.
REQ-012 SHALL have port tick_bit  output  CH: per-channel bit-rate enable pulse, one cycle wide.
REQ-013 SHALL have port cfg_err  output  CH: per-channel sticky configuration error.

Function
REQ-014 Each channel SHALL hold an ACC_W-bit accumulator acc and a log2(OVS)-bit counter os_cnt; channels SHALL be fully independent.
REQ-015 Effective increment SHALL be eff = min(inc_k, TOP); the sum acc+eff SHALL be computed at ACC_W+1 bits, so there is no intermediate wrap.
REQ-016 When en_k=1 and resync_k=0, acc >= TOP: acc <= acc+eff-TOP and tick_os_k <= 1 on the next clock.
REQ-017 When en_k=1 and resync_k=0, acc < TOP: acc <= acc+eff and tick_os_k <= 0.
REQ-018 tick_os SHALL be registered: it is high in cycle n+1 exactly when acc >= TOP in cycle n with the channel enabled.
REQ-019 On each cycle that sets tick_os_k, os_cnt SHALL advance modulo OVS.
REQ-020 tick_bit_k SHALL be set in that same cycle iff os_cnt was OVS-1 before the advance, so tick_bit never asserts without tick_os.
REQ-021 When en_k=0 and resync_k=0: acc and os_cnt SHALL hold, and tick_os_k and tick_bit_k SHALL be 0.
REQ-022 resync_k=1 SHALL have priority over en_k: acc <= 0, os_cnt <= OVS/2, and tick_os_k, tick_bit_k <= 0. The first bit tick then lands OVS/2 oversample ticks later, at mid-bit.
REQ-023 cfg_err_k SHALL set on any cycle with en_k=1 and inc_k > TOP; it SHALL stay set until reset; clamping per REQ-015 still applies.
REQ-024 inc_k=0 with en_k=1 SHALL be legal: acc holds and no ticks occur, unless acc >= TOP.
REQ-025 inc_k changes SHALL take effect in the same cycle, with no reset of phase.
REQ-026 ACC_W SHALL satisfy 2*TOP < 2^ACC_W; ACC_W=16 with TOP=31250 complies.

Reset
REQ-027 When rst_n=0 at a clock edge, every channel SHALL load acc=0, os_cnt=0, tick_os=0, tick_bit=0, cfg_err=0, overriding en and resync.
REQ-028 Reset asserted mid-operation SHALL take effect at the next edge; the first possible tick_os is then two cycles after the first edge with rst_n=1 and en=1, given eff >= TOP.
REQ-029 Outputs SHALL be undefined only before the first clock edge with rst_n=0.

Verification
REQ-030 TOP=10, OVS=4, inc0=5, en0=1 after reset -> acc 0,5,10,5,10...; tick_os0 every 2nd cycle; tick_bit0 every 8th cycle, coincident with tick_os0.
REQ-031 TOP=31250, inc0=1152 for 5000 cycles -> tick_os0 count = floor(5000*1152/31250) within ±1; no two consecutive tick_os0.
REQ-032 Steady run, then resync0 pulse -> that cycle's ticks are 0, acc=0, and tick_bit0 occurs on the 8th following tick_os0 (OVS=16); channel 1 is unaffected.
REQ-033 en0 dropped 3 cycles, then restored -> no ticks while low; acc and os_cnt resume from the held values.
REQ-034 TOP=10, inc0=25 -> cfg_err0=1 next cycle and stays 1; tick_os0 high every cycle after the first; cfg_err0 clears only on rst_n=0.
REQ-035 rst_n=0 during an active tick -> all outputs 0 next cycle; both channels restart from acc=0.
